wb_gpio: RTL and testbench
==========================

WB_GPIO -- requirements
Module: wb_gpio

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 32, meaning Wishbone address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 32, meaning Wishbone data width.
REQ-003 SHALL have parameter NUM_PINS, default 4, range 1..32, meaning GPIO pin count.
REQ-004 SHALL have port clk, input, 1, meaning the system clock.
REQ-005 SHALL have port rstn, input, 1, meaning reset, synchronous, active-low.
REQ-006 SHALL have port s, wb_if slave modport, WB_ADDR_WIDTH/WB_DATA_WIDTH, meaning the register access port.
REQ-007 SHALL have port gpio_i, input, NUM_PINS, meaning asynchronous pad inputs.
REQ-008 SHALL have port gpio_o, output, NUM_PINS, meaning pad output values.
REQ-009 SHALL have port gpio_oe, output, NUM_PINS, meaning pad output enables (1 = drive).
REQ-010 SHALL have port int_o, output, 1, meaning the level interrupt.

Function
REQ-011 SHALL decode registers on adr[4:2] as follows:
- 0x00 DATA_IN, RO: synchronized inputs.
- 0x04 DATA_OUT, RW.
- 0x08 DIR, RW.
- 0x0C IRQ_EN, RW.
- 0x10 IRQ_EDGE, RW: 0 = rising, 1 = falling.
- 0x14 IRQ_STATUS, W1C.
REQ-012 SHALL decode only adr[4:2]; upper address bits are ignored because the interconnect performs window selection.
REQ-013 SHALL read offsets 0x18/0x1C as 0, ignore writes to them, and still acknowledge.
REQ-014 SHALL read register bits at or above NUM_PINS as 0.
REQ-015 SHALL register ack: ack=1 in the cycle after cyc&stb&!ack, and ack=0 in the following cycle, so at most one access completes per 2 cycles.
REQ-016 SHALL never assert err.
REQ-017 SHALL present dat_r registered, valid in the ack cycle, and 0 otherwise.
REQ-018 SHALL apply writes at the clock edge that asserts ack, honouring sel per byte lane; bytes with sel=0 are unchanged.
REQ-019 SHALL drive gpio_o directly from the DATA_OUT flops and gpio_oe directly from the DIR flops.
REQ-020 SHALL pass each gpio_i bit through a 2-flop synchronizer; DATA_IN is the second flop.
REQ-021 SHALL sample DATA_IN into a delay flop; rising edge = DATA_IN&!delay, falling edge = !DATA_IN&delay.
REQ-022 SHALL set the corresponding IRQ_STATUS bit in the cycle after an edge matching the IRQ_EDGE polarity, regardless of IRQ_EN.
REQ-023 SHALL give pad-change to IRQ_STATUS set a latency of 3 clk edges.
REQ-024 SHALL, when an edge-set and a W1C clear hit the same bit in the same cycle, let the set win.
REQ-025 SHALL register int_o = |(IRQ_STATUS & IRQ_EN), one cycle after status or enable changes.
REQ-026 SHALL not alter IRQ_STATUS when IRQ_EDGE or DIR is written.
REQ-027 SHALL sample pads configured as outputs normally; they can raise interrupts on their own driven value.
REQ-028 SHALL run a 2-bit settle counter from 0 after reset release and suppress edge detection until it reaches 3, preventing spurious edges from synchronizer fill.

Reset
REQ-029 SHALL, while rstn=0 at a clk edge, clear to 0: DATA_OUT, DIR, IRQ_EN, IRQ_EDGE, IRQ_STATUS, synchronizer and delay flops, settle counter, ack, dat_r, and int_o.
REQ-030 SHALL, on reset asserted mid-access, drop ack and abandon the access; a pending write is lost.
REQ-031 SHALL, on leaving reset, hold all outputs at 0 until written: gpio_o=0, gpio_oe=0, int_o=0.

Structure
REQ-032 SHALL place register offset constants and field widths in package wb_gpio_pkg.
REQ-033 SHALL use one sub-module, wb_gpio_sync_edge (per-pin 2-flop sync + delay flop + rise/fall outputs), instantiated NUM_PINS times via generate.
REQ-034 SHALL keep the register file, Wishbone handshake, and settle counter in wb_gpio.

Verification
REQ-035 SHALL cover: write 0x04=0x5 with sel=0xF, then read 0x04 -> ack 1 cycle after stb, read 0x5, gpio_o=4'b0101.
REQ-036 SHALL cover: write 0x08=0xA -> gpio_oe=4'b1010; read 0x18 -> 0, acked.
REQ-037 SHALL cover: IRQ_EN=0x1, IRQ_EDGE=0, gpio_i[0] 0->1 -> IRQ_STATUS=0x1 after 3 edges, int_o=1 one cycle later; write 0x14=0x1 -> int_o=0.
REQ-038 SHALL cover: IRQ_EDGE=0x2, gpio_i[1] 1->0 with IRQ_EN=0 -> status bit1 set, int_o stays 0; IRQ_EN=0x2 -> int_o=1.
REQ-039 SHALL cover: W1C of bit0 in the same cycle as a new rising edge on pin 0 -> bit0 remains 1.
REQ-040 SHALL cover: gpio_i=0xF held through reset release -> no IRQ_STATUS bits set, DATA_IN reads 0xF after 2 cycles.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// Register map, field widths and byte-lane helpers for the Wishbone GPIO block.
package wb_gpio_pkg;

    localparam int REG_W = 32;
    localparam int SEL_W = REG_W / 8;

    localparam logic [7:0] OFF_DATA_IN    = 8'h00;
    localparam logic [7:0] OFF_DATA_OUT   = 8'h04;
    localparam logic [7:0] OFF_DIR        = 8'h08;
    localparam logic [7:0] OFF_IRQ_EN     = 8'h0C;
    localparam logic [7:0] OFF_IRQ_EDGE   = 8'h10;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'h14;

    localparam logic [1:0] SETTLE_DONE = 2'd3;

    typedef enum logic [2:0] {
        R_DATA_IN    = OFF_DATA_IN[4:2],
        R_DATA_OUT   = OFF_DATA_OUT[4:2],
        R_DIR        = OFF_DIR[4:2],
        R_IRQ_EN     = OFF_IRQ_EN[4:2],
        R_IRQ_EDGE   = OFF_IRQ_EDGE[4:2],
        R_IRQ_STATUS = OFF_IRQ_STATUS[4:2],
        R_RSV6       = 3'd6,
        R_RSV7       = 3'd7
    } reg_e;

    function automatic logic [REG_W-1:0] sel_mask(logic [SEL_W-1:0] sel);
        logic [REG_W-1:0] m;
        m = '0;
        for (int i = 0; i < SEL_W; i++) begin
            m[i*8 +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

    function automatic logic [REG_W-1:0] merge(
        logic [REG_W-1:0] old,
        logic [REG_W-1:0] wdat,
        logic [REG_W-1:0] m
    );
        return (old & ~m) | (wdat & m);
    endfunction

endpackage

// File: rtl/wb_if.sv
// Classic Wishbone single-access bus bundle.
interface wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                cyc;
    logic                stb;
    logic                we;
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W-1:0]   dat_w;
    logic [DATA_W/8-1:0] sel;
    logic [DATA_W-1:0]   dat_r;
    logic                ack;
    logic                err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_gpio_sync_edge.sv
// One pad: 2-flop synchronizer, delay flop and rise/fall detect.
module wb_gpio_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic pad,
    output logic data_in,
    output logic rise,
    output logic fall
);

    logic meta;
    logic dly;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta    <= 1'b0;
            data_in <= 1'b0;
            dly     <= 1'b0;
        end else begin
            meta    <= pad;
            data_in <= meta;
            dly     <= data_in;
        end
    end

    assign rise = data_in & ~dly;
    assign fall = ~data_in & dly;

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO: register file, bus handshake, edge interrupts.
module wb_gpio
    import wb_gpio_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int NUM_PINS      = 4
) (
    input  logic                clk,
    input  logic                rstn,
    wb_if.slave                 s,
    input  logic [NUM_PINS-1:0] gpio_i,
    output logic [NUM_PINS-1:0] gpio_o,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                int_o
);

    logic [WB_ADDR_WIDTH-1:0]   adr;
    logic [WB_DATA_WIDTH-1:0]   wraw;
    logic [WB_DATA_WIDTH/8-1:0] sraw;

    logic [NUM_PINS-1:0] dout;
    logic [NUM_PINS-1:0] dir;
    logic [NUM_PINS-1:0] ien;
    logic [NUM_PINS-1:0] iedge;
    logic [NUM_PINS-1:0] ist;
    logic [NUM_PINS-1:0] din;
    logic [NUM_PINS-1:0] rise;
    logic [NUM_PINS-1:0] fall;
    logic [NUM_PINS-1:0] set;
    logic [NUM_PINS-1:0] clr;

    logic [1:0]               settle;
    logic                     ack;
    logic                     irq;
    logic [WB_DATA_WIDTH-1:0] rdat;

    logic [REG_W-1:0] wdat;
    logic [REG_W-1:0] bmask;
    logic [REG_W-1:0] rval;
    reg_e             idx;
    logic             acc;
    logic             wr;
    logic             unused_bits;

    assign adr  = s.adr;
    assign wraw = s.dat_w;
    assign sraw = s.sel;

    assign acc   = s.cyc & s.stb & ~ack;
    assign wr    = acc & s.we;
    assign idx   = reg_e'(adr[4:2]);
    assign wdat  = REG_W'(wraw);
    assign bmask = sel_mask(SEL_W'(sraw));

    assign unused_bits = ^{adr, wraw, sraw};

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        wb_gpio_sync_edge u_sync (
            .clk     (clk),
            .rstn    (rstn),
            .pad     (gpio_i[i]),
            .data_in (din[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // Synchronizer fill after reset looks like edges; ignore them until settled.
    assign set = (settle == SETTLE_DONE)
               ? ((iedge & fall) | (~iedge & rise))
               : '0;

    assign clr = (wr && idx == R_IRQ_STATUS)
               ? NUM_PINS'(wdat & bmask)
               : '0;

    always_comb begin
        rval = '0;
        unique case (idx)
            R_DATA_IN:    rval = REG_W'(din);
            R_DATA_OUT:   rval = REG_W'(dout);
            R_DIR:        rval = REG_W'(dir);
            R_IRQ_EN:     rval = REG_W'(ien);
            R_IRQ_EDGE:   rval = REG_W'(iedge);
            R_IRQ_STATUS: rval = REG_W'(ist);
            default:      rval = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout   <= '0;
            dir    <= '0;
            ien    <= '0;
            iedge  <= '0;
            ist    <= '0;
            settle <= '0;
            ack    <= 1'b0;
            rdat   <= '0;
            irq    <= 1'b0;
        end else begin
            ack  <= acc;
            rdat <= acc ? WB_DATA_WIDTH'(rval) : '0;
            irq  <= |(ist & ien);
            // Set wins over a same-cycle W1C clear.
            ist  <= (ist & ~clr) | set;
            if (settle != SETTLE_DONE) begin
                settle <= settle + 2'd1;
            end
            if (wr) begin
                unique case (idx)
                    R_DATA_OUT:
                        dout <= NUM_PINS'(merge(REG_W'(dout), wdat, bmask));
                    R_DIR:
                        dir <= NUM_PINS'(merge(REG_W'(dir), wdat, bmask));
                    R_IRQ_EN:
                        ien <= NUM_PINS'(merge(REG_W'(ien), wdat, bmask));
                    R_IRQ_EDGE:
                        iedge <= NUM_PINS'(merge(REG_W'(iedge), wdat, bmask));
                    default: ;
                endcase
            end
        end
    end

    assign s.ack   = ack;
    assign s.dat_r = rdat;
    assign s.err   = 1'b0;
    assign gpio_o  = dout;
    assign gpio_oe = dir;
    assign int_o   = irq;

endmodule

// File: tb/tb_wb_gpio.sv
// Randomized + directed bench for wb_gpio against a pad-history model.
module tb_wb_gpio;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] gpio_i;
    logic [3:0] gpio_o;
    logic [3:0] gpio_oe;
    logic       int_o;

    wb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    wb_gpio #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .NUM_PINS      (4)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s       (bus.slave),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .int_o   (int_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model: registers plus the last few pad samples seen at clock edges.
    logic [3:0]  m_dout, m_dir, m_en, m_edg, m_st;
    logic        m_int, m_ack;
    logic [31:0] m_rd;
    int          m_edges;
    logic [3:0]  hist[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(logic [2:0] i);
        case (i)
            3'd0:    return 32'(hist[1]);
            3'd1:    return 32'(m_dout);
            3'd2:    return 32'(m_dir);
            3'd3:    return 32'(m_en);
            3'd4:    return 32'(m_edg);
            3'd5:    return 32'(m_st);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] lanes(logic [3:0] old, logic [31:0] w,
                                         logic [3:0] sel);
        logic [3:0] v;
        v = old;
        if (sel[0]) v = w[3:0];
        return v;
    endfunction

    task automatic m_step(logic r, logic cyc, logic stb, logic we,
                          logic [31:0] adr, logic [31:0] w, logic [3:0] sel,
                          logic [3:0] pad);
        logic       acc;
        logic [3:0] set, clr, now, prev;
        logic [2:0] i;
        if (!r) begin
            {m_dout, m_dir, m_en, m_edg, m_st} = '0;
            m_int = 0; m_ack = 0; m_rd = 0; m_edges = 0;
            hist = '{4'h0, 4'h0, 4'h0, 4'h0};
            return;
        end
        i    = adr[4:2];
        acc  = cyc && stb && !m_ack;
        now  = hist[1];
        prev = hist[2];
        set  = '0;
        if (m_edges >= 3)
            set = (m_edg & ~now & prev) | (~m_edg & now & ~prev);
        clr  = '0;
        m_int = |(m_st & m_en);
        m_rd  = acc ? m_reg(i) : 32'h0;
        m_ack = acc;
        if (acc && we) begin
            case (i)
                3'd1: m_dout = lanes(m_dout, w, sel);
                3'd2: m_dir  = lanes(m_dir, w, sel);
                3'd3: m_en   = lanes(m_en, w, sel);
                3'd4: m_edg  = lanes(m_edg, w, sel);
                3'd5: clr    = sel[0] ? w[3:0] : 4'h0;
                default: ;
            endcase
        end
        m_st = (m_st & ~clr) | set;
        hist.push_front(pad);
        void'(hist.pop_back());
        m_edges++;
    endtask

    task automatic tick();
        logic        r, cyc, stb, we;
        logic [31:0] adr, w;
        logic [3:0]  sel, pad;
        r = rstn; cyc = bus.cyc; stb = bus.stb; we = bus.we;
        adr = bus.adr; w = bus.dat_w; sel = bus.sel; pad = gpio_i;
        @(posedge clk);
        #1;
        m_step(r, cyc, stb, we, adr, w, sel, pad);
        chk("gpio_o", 32'(gpio_o), 32'(m_dout));
        chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
        chk("int_o", 32'(int_o), 32'(m_int));
        chk("ack", 32'(bus.ack), 32'(m_ack));
        chk("dat_r", bus.dat_r, m_rd);
        chk("err", 32'(bus.err), 32'h0);
    endtask

    task automatic idle();
        bus.cyc = 0; bus.stb = 0; bus.we = 0;
    endtask

    task automatic wr(logic [31:0] adr, logic [31:0] d);
        bus.cyc = 1; bus.stb = 1; bus.we = 1;
        bus.adr = adr; bus.dat_w = d; bus.sel = 4'hF;
        tick();
        chk("wr_ack", 32'(bus.ack), 32'h1);
        idle();
        tick();
    endtask

    task automatic rd(string tag, logic [31:0] adr, logic [31:0] exp);
        bus.cyc = 1; bus.stb = 1; bus.we = 0;
        bus.adr = adr; bus.dat_w = 32'h0; bus.sel = 4'hF;
        tick();
        chk("rd_ack", 32'(bus.ack), 32'h1);
        chk(tag, bus.dat_r, exp);
        idle();
        tick();
    endtask

    initial begin
        logic [31:0] r;
        rstn = 0; gpio_i = 4'h0;
        bus.adr = 0; bus.dat_w = 0; bus.sel = 0;
        idle();
        repeat (3) tick();
        rstn = 1;
        repeat (4) tick();

        // Basic RW, lane masking, address aliasing
        wr(32'h04, 32'h5);
        chk("gpio_o_5", 32'(gpio_o), 32'h5);
        rd("dout", 32'h04, 32'h5);
        rd("dout_alias", 32'hFFFF_FF04, 32'h5);
        wr(32'h08, 32'hA);
        chk("gpio_oe_a", 32'(gpio_oe), 32'hA);
        rd("rsv18", 32'h18, 32'h0);
        wr(32'h1C, 32'hF);
        rd("rsv1c", 32'h1C, 32'h0);

        // Rising edge interrupt on pin 0
        wr(32'h0C, 32'h1);
        wr(32'h10, 32'h0);
        gpio_i[0] = 1;
        repeat (3) tick();
        chk("int_pre", 32'(int_o), 32'h0);
        tick();
        chk("int_rise", 32'(int_o), 32'h1);
        rd("st_rise", 32'h14, 32'h1);
        wr(32'h14, 32'h1);
        chk("int_clr", 32'(int_o), 32'h0);

        // Falling edge on pin 1 with interrupt disabled
        wr(32'h0C, 32'h0);
        wr(32'h10, 32'h2);
        gpio_i[1] = 1;
        repeat (5) tick();
        gpio_i[1] = 0;
        repeat (5) tick();
        chk("int_masked", 32'(int_o), 32'h0);
        rd("st_fall", 32'h14, 32'h2);
        wr(32'h0C, 32'h2);
        chk("int_en", 32'(int_o), 32'h1);

        // Edge-set beats same-cycle W1C on pin 0
        wr(32'h10, 32'h3);
        gpio_i[0] = 0;
        repeat (5) tick();
        rd("st_pre", 32'h14, 32'h3);
        wr(32'h10, 32'h2);
        gpio_i[0] = 1;
        tick();
        tick();
        wr(32'h14, 32'h1);
        rd("st_setwin", 32'h14, 32'h3);

        // Pads high through reset release
        gpio_i = 4'hF;
        rstn = 0;
        repeat (3) tick();
        chk("rst_gpio_o", 32'(gpio_o), 32'h0);
        rstn = 1;
        tick();
        tick();
        rd("din_f", 32'h00, 32'hF);
        rd("st_quiet", 32'h14, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.cyc = ($urandom_range(0, 3) != 0);
            bus.stb = ($urandom_range(0, 3) != 0);
            bus.we  = ($urandom_range(0, 1) != 0);
            bus.adr = $urandom;
            bus.dat_w = $urandom;
            r = $urandom;
            bus.sel = r[3:0];
            if ($urandom_range(0, 5) == 0)
                gpio_i = gpio_i ^ 4'(1 << $urandom_range(0, 3));
            rstn = ($urandom_range(0, 399) != 0);
            tick();
        end
        rstn = 1;
        idle();
        repeat (4) tick();

        // Reset in the middle of a write access
        wr(32'h04, 32'h3);
        bus.cyc = 1; bus.stb = 1; bus.we = 1;
        bus.adr = 32'h04; bus.dat_w = 32'hC; bus.sel = 4'hF;
        rstn = 0;
        tick();
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_dout", 32'(gpio_o), 32'h0);
        idle();
        rstn = 1;
        tick();
        rd("dout_lost", 32'h04, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
